// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared constants for the RV32I front end (fetch and decode).
//   RV_NOP           canonical NOP encoding (addi x0, x0, 0)
//   DEFAULT_RESET_PC default first fetch address after reset
//   OP_*             major opcode values (inst[6:0]) used by core_decode
// -----------------------------------------------------------------------------
package core_pkg;

  localparam logic [31:0] RV_NOP           = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Word-align an address by clearing the two byte-offset bits.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// -----------------------------------------------------------------------------
// core_fetch_fifo
//   Prefetch buffer for core_fetch. Entries are {pc[63:32], inst[31:0]}.
//   The head entry lives in a dedicated output register (head_valid/head_data);
//   up to DEPTH further entries wait in storage behind it. When the head is
//   free (empty or popped) it is refilled from storage, or directly from the
//   push data when storage is empty, so a push and a pop in the same cycle
//   keep a back-to-back stream without a bubble.
// Ports
//   CLK, RST_N  clock, synchronous active-low reset
//   flush       drop every entry including the head (wins over push/pop)
//   push        write push_data (caller guarantees storage never overflows)
//   push_data   {pc, inst}
//   pop         consume the head entry (only meaningful while head_valid)
//   count       number of entries in storage, head register excluded
//   head_valid  head_data holds a real entry
//   head_data   registered head entry; {32'h0, BUBBLE} while empty
// -----------------------------------------------------------------------------
module core_fetch_fifo
  import core_pkg::*;
#(
  parameter int          DEPTH  = 2,
  parameter logic [31:0] BUBBLE = 32'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   flush,
  input  logic                   push,
  input  logic [63:0]            push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output logic [63:0]            head_data
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [63:0] IDLE_HEAD = {32'h0000_0000, BUBBLE};

  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          head_valid_r;
  logic [63:0]   head_data_r;

  logic          head_free_s;
  logic          stor_pop_s;
  logic          stor_push_s;
  logic          head_valid_nxt_s;
  logic [63:0]   head_data_nxt_s;
  logic [CW-1:0] count_nxt_s;

  // Head refill selection and storage occupancy bookkeeping.
  always_comb begin
    head_free_s      = ~head_valid_r | pop;
    stor_pop_s       = head_free_s & (count_r != {CW{1'b0}});
    // A push bypasses storage when it can go straight into a free head.
    stor_push_s      = push & ~(head_free_s & (count_r == {CW{1'b0}}));
    head_valid_nxt_s = head_valid_r;
    head_data_nxt_s  = head_data_r;
    count_nxt_s      = count_r;

    if (head_free_s) begin
      if (stor_pop_s) begin
        head_valid_nxt_s = 1'b1;
        head_data_nxt_s  = mem_r[rd_ptr_r];
      end else if (push) begin
        head_valid_nxt_s = 1'b1;
        head_data_nxt_s  = push_data;
      end else begin
        head_valid_nxt_s = 1'b0;
        head_data_nxt_s  = IDLE_HEAD;
      end
    end else begin
      head_valid_nxt_s = head_valid_r;
      head_data_nxt_s  = head_data_r;
    end

    case ({stor_push_s, stor_pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      head_valid_r <= 1'b0;
      head_data_r  <= IDLE_HEAD;
    end else if (flush) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      head_valid_r <= 1'b0;
      head_data_r  <= IDLE_HEAD;
    end else begin
      if (stor_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (stor_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r      <= count_nxt_s;
      head_valid_r <= head_valid_nxt_s;
      head_data_r  <= head_data_nxt_s;
    end
  end

  // Storage array write port; contents need no reset.
  always_ff @(posedge CLK) begin
    if (stor_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign count      = count_r;
  assign head_valid = head_valid_r;
  assign head_data  = head_data_r;

endmodule

// File: rtl/core_fetch.sv
// -----------------------------------------------------------------------------
// core_fetch
//   RV32I instruction fetch stage. Holds the PC, issues in-order word fetches,
//   buffers returned words in core_fetch_fifo and presents them to decode
//   with their PC. Redirect flushes the buffer and restarts at the target;
//   responses still in flight at that point are counted in kill_r and dropped.
// Ports
//   CLK, RST_N              clock, synchronous active-low reset
//   IMEM_REQ/ADDR/GNT       fetch request handshake (REQ & GNT)
//   IMEM_RVALID/RDATA       response, one cycle after each handshake, in order
//   STALL                   decode cannot accept; INST* held
//   REDIRECT/REDIRECT_PC    flush and restart (highest priority)
//   INST/INST_PC/INST_VALID registered instruction to decode
// Configuration
//   CORE_FETCH_NOP_BUBBLE_EN  when defined, INST shows RV_NOP while empty;
//                             otherwise INST shows 32'h0000_0000.
// -----------------------------------------------------------------------------
module core_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] INST,
  output logic [31:0] INST_PC,
  output logic        INST_VALID
);

`ifdef CORE_FETCH_NOP_BUBBLE_EN
  localparam logic [31:0] BUBBLE_INST = RV_NOP;
`else
  localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;
`endif

  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W    = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0]   pc_r;
  logic [31:0]   rsp_pc_r;
  logic [CW-1:0] out_r;
  logic [CW-1:0] kill_r;

  logic [CW-1:0] fifo_count_s;
  logic          head_valid_s;
  logic [63:0]   head_data_s;
  logic [CW:0]   occ_s;
  logic          req_s;
  logic          hs_s;
  logic          rv_live_s;
  logic          rv_dead_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] out_nxt_s;
  logic [CW-1:0] kill_nxt_s;
  logic [CW-1:0] inflight_nxt_s;

  // Issue gating, response classification and in-flight counter updates.
  always_comb begin
    // Buffered plus live outstanding words must leave a slot for every response.
    occ_s     = {1'b0, fifo_count_s} + {1'b0, out_r};
    req_s     = RST_N & ~REDIRECT & (occ_s < DEPTH_W);
    hs_s      = req_s & IMEM_GNT;
    // Responses are in order, so killed ones always arrive before live ones.
    rv_dead_s = IMEM_RVALID & (kill_r != {CW{1'b0}});
    rv_live_s = IMEM_RVALID & (kill_r == {CW{1'b0}});
    push_s    = rv_live_s & ~REDIRECT;
    pop_s     = head_valid_s & ~STALL;

    case ({hs_s, rv_live_s})
      2'b10:   out_nxt_s = out_r + CW'(1'b1);
      2'b01:   out_nxt_s = out_r - CW'(1'b1);
      default: out_nxt_s = out_r;
    endcase

    if (rv_dead_s) begin
      kill_nxt_s = kill_r - CW'(1'b1);
    end else begin
      kill_nxt_s = kill_r;
    end

    // Everything still in flight after this cycle becomes dead on a redirect.
    inflight_nxt_s = out_nxt_s + kill_nxt_s;
  end

  // PC, response PC and in-flight counters.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_r     <= RESET_PC_W;
      rsp_pc_r <= 32'h0000_0000;
      out_r    <= {CW{1'b0}};
      kill_r   <= {CW{1'b0}};
    end else if (REDIRECT) begin
      pc_r     <= word_align(REDIRECT_PC);
      rsp_pc_r <= rsp_pc_r;
      out_r    <= {CW{1'b0}};
      kill_r   <= inflight_nxt_s;
    end else begin
      if (hs_s) begin
        pc_r     <= pc_r + 32'd4;
        rsp_pc_r <= pc_r;
      end
      out_r  <= out_nxt_s;
      kill_r <= kill_nxt_s;
    end
  end

  core_fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .BUBBLE (BUBBLE_INST)
  ) u_fifo (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .flush      (REDIRECT),
    .push       (push_s),
    .push_data  ({rsp_pc_r, IMEM_RDATA}),
    .pop        (pop_s),
    .count      (fifo_count_s),
    .head_valid (head_valid_s),
    .head_data  (head_data_s)
  );

  assign IMEM_REQ   = req_s;
  assign IMEM_ADDR  = pc_r;
  assign INST       = head_data_s[31:0];
  assign INST_PC    = head_data_s[63:32];
  assign INST_VALID = head_valid_s;

endmodule
